// File: rtl/visor_pkg.sv
// Shared types and constants for the adder-sum 7-segment viewer.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package visor_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int N_BITS = 5;
    localparam int N_ITER = 5;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Double-dabble correction: a nibble >= 5 would overflow past 9 after doubling.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bcd_a_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder; codes 10..15 blank.
module bcd_a_7seg
    import visor_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/visor_suma_7seg.sv
// Converts the 5-bit adder sum {co, zi} to two BCD digits with a sequential
// shift-add-3 engine and drives a 2-digit multiplexed common-anode display.
module visor_suma_7seg
    import visor_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter int BLANK_ZERO = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       co,
    input  logic [3:0] zi,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd_dec,
    output logic [3:0] bcd_uni,
    output logic [6:0] seg,
    output logic [1:0] an
);

    state_t                 state_q, state_d;
    logic [N_BITS-1:0]      shift_q, shift_d;
    logic [7:0]             scratch_q, scratch_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [3:0]             bcd_dec_q, bcd_dec_d;
    logic [3:0]             bcd_uni_q, bcd_uni_d;
    logic                   done_q, done_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [1:0]             an_q, an_d;
    logic [6:0]             seg_q, seg_d;

    logic [7:0]             adj;
    logic [7+N_BITS:0]      shifted;
    logic                   tens_sel;
    logic [3:0]             digit;
    logic [6:0]             digit_seg;

    // Conversion engine: one adjust-then-shift iteration per SHIFT cycle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_dec_d = bcd_dec_q;
        bcd_uni_d = bcd_uni_q;
        done_d    = 1'b0;

        adj     = {add3(scratch_q[7:4]), add3(scratch_q[3:0])};
        shifted = {adj, shift_q} << 1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = {co, zi};
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted[7+N_BITS:N_BITS];
                shift_d   = shifted[N_BITS-1:0];
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == 3'(N_ITER - 1)) begin
                    bcd_dec_d = shifted[7+N_BITS:4+N_BITS];
                    bcd_uni_d = shifted[3+N_BITS:N_BITS];
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Display path shows only the committed result, never the scratch.
    always_comb begin
        div_d    = div_q + 1'b1;
        tens_sel = div_q[DIV_WIDTH-1];
        digit    = tens_sel ? bcd_dec_q : bcd_uni_q;
        an_d     = tens_sel ? 2'b01 : 2'b10;
        if (tens_sel && (BLANK_ZERO != 0) && (bcd_dec_q == 4'd0)) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = digit_seg;
        end
    end

    bcd_a_7seg u_dec (
        .bcd (digit),
        .seg (digit_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_dec_q <= '0;
            bcd_uni_q <= '0;
            done_q    <= 1'b0;
            div_q     <= '0;
            an_q      <= 2'b10;
            seg_q     <= SEG_0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_dec_q <= bcd_dec_d;
            bcd_uni_q <= bcd_uni_d;
            done_q    <= done_d;
            div_q     <= div_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = done_q;
    assign bcd_dec = bcd_dec_q;
    assign bcd_uni = bcd_uni_q;
    assign seg     = seg_q;
    assign an      = an_q;

endmodule
